timer_arbiter: RTL and testbench
================================

# timer_arbiter

Round-robin controller that shares one `timer_ip` instance among `N_REQ` requesters. It acts as the sole bus master on the timer's register port. Per grant it programs LOAD, starts the timer in one-shot mode, waits for `timeout`, disables the timer, and returns a one-cycle `done` pulse to the winning requester. It sits between software-facing requester logic and `timer_ip`, so no requester drives the timer bus directly.

## Interface
- `N_REQ`, 4: number of requesters, range 2..8.
- `IDX_W`, 2: width of grant index; must equal clog2(`N_REQ`).
- `clk` in 1: single clock; all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req` in `N_REQ`: level request per requester; hold until `done` (or abort).
- `load_val` in 32*`N_REQ`: per-requester LOAD value; slice i = bits [32i+31:32i]; sampled at grant.
- `grant` out `N_REQ`: one-hot, high from grant cycle through `done` cycle.
- `grant_idx` out `IDX_W`: index of current or last grant.
- `done` out `N_REQ`: one-cycle completion pulse to the granted requester.
- `busy` out 1: high whenever state is not IDLE.
- `t_sel` out 1, `t_we` out 1, `t_addr` out 32, `t_wdata` out 32: timer bus master; all registered.
- `t_timeout` in 1: timer `timeout` output.

## Operation
- Timer register map driven: CTRL 0x00 (bit0 en, bit1 mode), LOAD 0x04. Only one-shot mode is used (mode=0).
- States and transitions:
  - IDLE: on any `req` → WR_LOAD.
  - WR_LOAD → WR_CTRL.
  - WR_CTRL → WAIT.
  - WAIT: on `t_timeout`=1 → WR_DIS.
  - WR_DIS → DONE.
  - DONE → DRAIN.
  - DRAIN: on `t_timeout`=0 → IDLE.
- Arbitration in IDLE: round-robin. Search starts at last grant index +1, mod `N_REQ`. Reset pointer = `N_REQ`-1, so requester 0 wins first.
- WR_LOAD: `t_sel`=`t_we`=1, `t_addr`=0x04, `t_wdata`=latched `load_val`.
- WR_CTRL: address 0x00, data 0x1.
- WR_DIS: address 0x00, data 0x0.
- All other states: `t_sel`=`t_we`=0, `t_addr`=`t_wdata`=0.
- Zero load: if the latched `load_val`=0, skip WR_LOAD, WR_CTRL and WAIT and go IDLE→DONE. No timer access occurs.
- DRAIN tolerates `t_timeout` being either a pulse or a level that clears on disable.
- `req` from non-granted requesters is ignored until the next IDLE.
- A `req` that is still high after its own `done` is eligible again, at lowest round-robin priority.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `grant_idx`=0, all `t_*`=0, state=IDLE, RR pointer=`N_REQ`-1.
- Req sampled high in IDLE at edge N:
  - `grant`, `busy` and the LOAD write are visible in cycle N+1.
  - CTRL write in N+2.
  - WAIT from N+3.
- `t_timeout` sampled high in WAIT at edge M:
  - CTRL=0 write in M+1.
  - `done` pulse in M+2, with `grant` still high.
  - `grant` drops in M+3 (DRAIN).
- Minimum gap between consecutive grants: 2 cycles (DRAIN, then IDLE).
- Zero-load latency: `grant` and `done` both high in N+1; `grant` low in N+2.
- `t_timeout` high while in IDLE, WR_LOAD or WR_CTRL is ignored.
- Reset mid-operation: all outputs go to their reset values immediately. `timer_ip` shares `resetn`, so no disable write is needed.

## Configuration
- `TIMER_ARB_ABORT_EN` defined:
  - In WR_LOAD, WR_CTRL or WAIT, granted `req` sampled low → WR_DIS → DRAIN (DONE is skipped).
  - No `done` pulse; `grant` drops in the cycle after WR_DIS.
- `TIMER_ARB_ABORT_EN` undefined: `req` is ignored after grant; the sequence always runs to `done`.

## Test plan
- Single request: `req`[0]=1, load 10.
  - Writes (0x04,10) then (0x00,1) on consecutive cycles.
  - After `t_timeout`: write (0x00,0), then exactly one `done`[0] pulse two cycles after timeout.
- Round-robin: `req`=4'b1111 held, loads 3/4/5/6.
  - Grant order 0,1,2,3,0.
  - Each `done` one cycle wide; never two `grant` bits high at once.
- Zero load: `req`[1]=1, `load_val`[1]=0.
  - `done`[1] in the cycle after the request is seen; `t_sel` never asserts.
- Abort, with macro: `req`[2] dropped in WAIT.
  - (0x00,0) written; no `done`[2]; `busy` low within 3 cycles once `t_timeout`=0.
- Abort, without macro: same stimulus.
  - `done`[2] still pulses after the timeout.
- Level timeout and reset:
  - `t_timeout` held high for 5 cycles after disable → no new grant until it falls.
  - `resetn` low during WAIT → all outputs 0; next `req`=4'b1111 grants requester 0 first.

Source files
------------

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one timer_ip among N_REQ requesters (LOAD, start, wait, disable, done).
// Optional TIMER_ARB_ABORT_EN: a granted requester dropping req before timeout disables the timer with no done.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   load_val,
  output logic [N_REQ-1:0]      grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic                  t_sel,
  output logic                  t_we,
  output logic [31:0]           t_addr,
  output logic [31:0]           t_wdata,
  input  logic                  t_timeout
);
  localparam logic [31:0] ADDR_CTRL = 32'h0;
  localparam logic [31:0] ADDR_LOAD = 32'h4;

  typedef enum logic [2:0] {IDLE, WR_LOAD, WR_CTRL, WAIT, WR_DIS, DONE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        ptr, win_idx, cur_idx;
  logic                    win_vld, zero_load;
  logic [N_REQ-1:0]        cur_oh;
  logic [N_REQ-1:0][31:0]  lv;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lv
    assign lv[i] = load_val[32*i +: 32];
  end

  // Round-robin: scan from ptr+1 upward with wrap; first requester found wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == IDX_W'(N_REQ-1)) ? '0 : cand + IDX_W'(1);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign zero_load = (lv[win_idx] == 32'h0);
  assign cur_idx   = (state == IDLE) ? win_idx : grant_idx;
  assign cur_oh    = N_REQ'(1) << cur_idx;
  assign busy      = (state != IDLE);

`ifdef TIMER_ARB_ABORT_EN
  logic abort_now, abort_q;
  assign abort_now = (state inside {WR_LOAD, WR_CTRL, WAIT}) && !req[grant_idx];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = zero_load ? DONE : WR_LOAD;
      WR_LOAD: state_nxt = WR_CTRL;
      WR_CTRL: state_nxt = WAIT;
      WAIT:    if (t_timeout) state_nxt = WR_DIS;
`ifdef TIMER_ARB_ABORT_EN
      WR_DIS:  state_nxt = abort_q ? DRAIN : DONE;
`else
      WR_DIS:  state_nxt = DONE;
`endif
      DONE:    state_nxt = DRAIN;
      // Wait out a level-style timeout so it cannot complete the next grant.
      DRAIN:   if (!t_timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef TIMER_ARB_ABORT_EN
    if (abort_now) state_nxt = WR_DIS;
`endif
  end

  // All outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N_REQ-1);
      grant_idx <= '0;
      grant     <= '0;
      done      <= '0;
      t_sel     <= 1'b0;
      t_we      <= 1'b0;
      t_addr    <= '0;
      t_wdata   <= '0;
`ifdef TIMER_ARB_ABORT_EN
      abort_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        grant_idx <= win_idx;
        ptr       <= win_idx;
      end
      grant <= (state_nxt inside {WR_LOAD, WR_CTRL, WAIT, WR_DIS, DONE}) ? cur_oh : '0;
      done  <= (state_nxt == DONE) ? cur_oh : '0;
      t_sel <= state_nxt inside {WR_LOAD, WR_CTRL, WR_DIS};
      t_we  <= state_nxt inside {WR_LOAD, WR_CTRL, WR_DIS};
      case (state_nxt)
        WR_LOAD: begin t_addr <= ADDR_LOAD; t_wdata <= lv[win_idx]; end
        WR_CTRL: begin t_addr <= ADDR_CTRL; t_wdata <= 32'h1;       end
        default: begin t_addr <= ADDR_CTRL; t_wdata <= 32'h0;       end
      endcase
`ifdef TIMER_ARB_ABORT_EN
      if (state_nxt == WR_DIS) abort_q <= abort_now;
`endif
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed test-plan segments plus randomized traffic, checked every cycle
// against a timestamp-based reference model of grant/done/bus timing.
module tb_timer_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] load_val = '0;
  logic            t_timeout = 1'b0;
  logic [N-1:0]    grant, done;
  logic [IW-1:0]   grant_idx;
  logic            busy, t_sel, t_we;
  logic [31:0]     t_addr, t_wdata;

  timer_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
    .clk(clk), .resetn(resetn), .req(req), .load_val(load_val),
    .grant(grant), .grant_idx(grant_idx), .done(done), .busy(busy),
    .t_sel(t_sel), .t_we(t_we), .t_addr(t_addr), .t_wdata(t_wdata),
    .t_timeout(t_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge-stamped grant history; outputs follow from the timestamps.
  int          cyc, g, g_edge, m_edge, a_edge, drain_edge, ptr, last_idx, mc, endg;
  bit          have_m, have_a, zero;
  logic [31:0] l;
  logic [N-1:0] e_grant, e_done;
  logic        e_busy, e_sel;
  logic [31:0] e_addr, e_wdata;
  int          e_idx;

  task automatic model_edge();
    if (!resetn) begin
      cyc = 0; g = -1; ptr = N-1; last_idx = 0; have_m = 0; have_a = 0; zero = 0;
      e_grant = '0; e_done = '0; e_busy = 0; e_sel = 0; e_addr = 0; e_wdata = 0; e_idx = 0;
      return;
    end
    cyc++;
    if (g < 0) begin
      for (int k = 1; k <= N; k++)
        if (g < 0 && req[(ptr+k)%N]) g = (ptr+k)%N;
      if (g >= 0) begin
        ptr = g; last_idx = g; g_edge = cyc;
        l = load_val[32*g +: 32];
        zero = (l == 0);
        have_a = 0; have_m = zero; m_edge = cyc - 1;
        drain_edge = cyc + 2;
      end
    end else if (!have_m && !have_a) begin
`ifdef TIMER_ARB_ABORT_EN
      if (!req[g]) begin have_a = 1; a_edge = cyc; drain_edge = cyc + 2; end else
`endif
      if (cyc >= g_edge + 3 && t_timeout) begin have_m = 1; m_edge = cyc; drain_edge = cyc + 3; end
    end else if (cyc >= drain_edge && !t_timeout) begin
      g = -1;
    end
    mc   = cyc + 1;
    endg = have_a ? a_edge + 1 : (have_m ? m_edge + 2 : 1 << 30);
    e_busy  = (g >= 0);
    e_grant = (g >= 0 && mc <= endg) ? (N'(1) << g) : '0;
    e_done  = (g >= 0 && have_m && mc == m_edge + 2) ? (N'(1) << g) : '0;
    e_sel = 0; e_addr = 0; e_wdata = 0;
    if (g >= 0 && !zero) begin
      if (mc == g_edge + 1) begin e_sel = 1; e_addr = 32'h4; e_wdata = l; end
      if (mc == g_edge + 2) begin e_sel = 1; e_addr = 32'h0; e_wdata = 32'h1; end
      if ((have_m && mc == m_edge + 1) || (have_a && mc == a_edge + 1)) begin
        e_sel = 1; e_addr = 32'h0; e_wdata = 32'h0;
      end
    end
    e_idx = last_idx;
  endtask

  int          done_cnt [N];
  int          sel_seen;
  int          order [$];
  logic [N-1:0] prev_grant = '0;

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("grant", grant, e_grant);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("grant_idx", grant_idx, e_idx);
    chk("t_sel", t_sel, e_sel);
    chk("t_we", t_we, e_sel);
    chk("t_addr", t_addr, e_addr);
    chk("t_wdata", t_wdata, e_wdata);
    chk("onehot", $countones(grant) <= 1, 1);
    if (t_sel) sel_seen++;
    for (int i = 0; i < N; i++) if (done[i]) done_cnt[i]++;
    if (grant != 0 && prev_grant == 0) order.push_back(int'(grant_idx));
    prev_grant = grant;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    sel_seen = 0;
    order.delete();
  endtask

  task automatic apply_reset(input string tag);
    step();
    resetn = 1'b0;
    #1;
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx"}, grant_idx, 0);
    chk({tag, "_sel"}, {t_sel, t_we}, 0);
    chk({tag, "_addr"}, t_addr, 0);
    chk({tag, "_wdata"}, t_wdata, 0);
    req = '0;
    t_timeout = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic idle_wait();
    int k;
    k = 0;
    req = '0;
    while (busy && k < 60) begin
      t_timeout = k[0];
      step();
      k++;
    end
    t_timeout = 1'b0;
    chk("idle_wait", busy, 0);
  endtask

  int to_burst = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single request, load 10
    apply_reset("rst");
    clr_counts();
    load_val[31:0] = 32'd10;
    req = 4'b0001;
    step();
    chk("single_load_addr", t_addr, 32'h4);
    chk("single_load_data", t_wdata, 32'd10);
    step();
    chk("single_ctrl_addr", t_addr, 32'h0);
    chk("single_ctrl_data", t_wdata, 32'h1);
    repeat (4) step();
    t_timeout = 1'b1;
    step();
    t_timeout = 1'b0;
    chk("single_dis_sel", t_sel, 1);
    chk("single_dis_data", t_wdata, 32'h0);
    step();
    chk("single_done", done, 4'b0001);
    req = '0;
    repeat (3) step();
    chk("single_done_cnt", done_cnt[0], 1);

    // Round-robin with all four requesting
    apply_reset("rst_rr");
    clr_counts();
    req = 4'b1111;
    load_val = {32'd6, 32'd5, 32'd4, 32'd3};
    for (int k = 0; k < 200 && order.size() < 5; k++) begin
      t_timeout = (k % 4 == 3);
      step();
    end
    chk("rr_count", order.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (order.size() > i) ? order[i] : -1, i % 4);
    idle_wait();

    // Zero load on requester 1
    clr_counts();
    load_val[63:32] = 32'd0;
    req = 4'b0010;
    step();
    chk("zero_grant", grant, 4'b0010);
    chk("zero_done", done, 4'b0010);
    req = '0;
    step();
    chk("zero_grant_drop", grant, 0);
    repeat (3) step();
    chk("zero_no_sel", sel_seen, 0);
    idle_wait();

    // Requester 2 drops req while waiting for the timeout
    clr_counts();
    load_val[95:64] = 32'd20;
    req = 4'b0100;
    repeat (3) step();
    req = '0;
    repeat (3) step();
`ifdef TIMER_ARB_ABORT_EN
    chk("abort_busy", busy, 0);
`else
    chk("abort_busy", busy, 1);
`endif
    t_timeout = 1'b1;
    step();
    t_timeout = 1'b0;
    repeat (4) step();
`ifdef TIMER_ARB_ABORT_EN
    chk("abort_done_cnt", done_cnt[2], 0);
`else
    chk("abort_done_cnt", done_cnt[2], 1);
`endif
    idle_wait();

    // Level timeout held through DRAIN blocks the next grant
    clr_counts();
    load_val[127:96] = 32'd7;
    load_val[31:0]   = 32'd7;
    req = 4'b1001;
    step();
    chk("level_first", grant, 4'b1000);
    repeat (2) step();
    t_timeout = 1'b1;
    repeat (8) step();
    chk("level_hold_grant", grant, 0);
    chk("level_hold_busy", busy, 1);
    t_timeout = 1'b0;
    step();
    step();
    chk("level_next_grant", grant, 4'b0001);
    idle_wait();

    // Reset while waiting for the timeout
    clr_counts();
    load_val[63:32] = 32'd50;
    req = 4'b0010;
    repeat (4) step();
    apply_reset("rst_wait");
    req = 4'b1111;
    step();
    chk("rst_first_grant", grant, 4'b0001);
    idle_wait();

    // Randomized traffic
    apply_reset("rst_rand");
    clr_counts();
    for (int k = 0; k < 3000; k++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (done[i] && $urandom_range(0, 2) != 0) req[i] = 1'b0;
`ifdef TIMER_ARB_ABORT_EN
          else if (grant[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
`endif
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
        load_val[32*i +: 32] = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      end
      if (to_burst > 0) begin
        t_timeout = 1'b1;
        to_burst--;
      end else begin
        t_timeout = 1'b0;
        if ($urandom_range(0, 3) == 0) to_burst = $urandom_range(1, 4);
      end
    end
    idle_wait();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
